sw_array_ctrl: RTL and testbench

Sequencer for the linear Smith-Waterman PE array (one PE per read base, one signed score per cell). It clears the array, then serially preloads the read bases into the PEs. It then streams reference bases with per-PE wavefront valids and drains the pipeline. Throughout, it tracks the best cell score and its (row, col). It sits between the host/DMA streams and the PE chain.

---
 rtl/sw_array_ctrl_if.sv | 49 ++++
 rtl/sw_array_ctrl.sv | 122 ++++++++++++
 tb/tb_sw_array_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sw_array_ctrl_if.sv
// Handshake and PE-array bundle for the Smith-Waterman array sequencer.
// slave: controller side; master: host/DMA and PE chain side.
interface sw_array_ctrl_if #(
    parameter int N_PE    = 16,
    parameter int SCORE_W = 8,
    parameter int COL_W   = 16
);
    localparam int ROW_W = (N_PE > 1) ? $clog2(N_PE) : 1;

    logic                      start;
    logic                      abort;
    logic                      rd_valid;
    logic [1:0]                rd_base;
    logic                      rd_ready;
    logic                      ref_valid;
    logic [1:0]                ref_base;
    logic                      ref_last;
    logic                      ref_ready;
    logic                      clear_en;
    logic [N_PE-1:0]           read_load_en;
    logic [1:0]                read_base_out;
    logic                      compute_en;
    logic [1:0]                ref_base_out;
    logic [N_PE-1:0]           in_valid_vec;
    logic [N_PE*SCORE_W-1:0]   pe_score_in;
    logic                      busy;
    logic                      done;
    logic [SCORE_W-1:0]        best_score;
    logic [ROW_W-1:0]          best_row;
    logic [COL_W-1:0]          best_col;

    modport slave (
        input  start, abort, rd_valid, rd_base,
        input  ref_valid, ref_base, ref_last, pe_score_in,
        output rd_ready, ref_ready, clear_en,
        output read_load_en, read_base_out,
        output compute_en, ref_base_out, in_valid_vec,
        output busy, done, best_score, best_row, best_col
    );

    modport master (
        output start, abort, rd_valid, rd_base,
        output ref_valid, ref_base, ref_last, pe_score_in,
        input  rd_ready, ref_ready, clear_en,
        input  read_load_en, read_base_out,
        input  compute_en, ref_base_out, in_valid_vec,
        input  busy, done, best_score, best_row, best_col
    );
endinterface

// File: rtl/sw_array_ctrl.sv
// Sequencer for a linear Smith-Waterman PE array: clear, read preload,
// reference streaming with wavefront valids, drain, best-cell tracking.
// Ports: clk, rst (async, active high), bus (sw_array_ctrl_if.slave).
module sw_array_ctrl #(
    parameter int N_PE    = 16,
    parameter int SCORE_W = 8,
    parameter int COL_W   = 16
) (
    input  logic           clk,
    input  logic           rst,
    sw_array_ctrl_if.slave bus
);
    localparam int ROW_W = (N_PE > 1) ? $clog2(N_PE) : 1;
    localparam int SR_W  = (N_PE > 1) ? N_PE - 1 : 1;

    typedef enum logic [2:0] {
        IDLE, CLEAR, LOAD, STREAM, DRAIN, DONE
    } state_t;

    state_t state, nxt;

    logic [ROW_W-1:0]   ld_cnt;
    logic [ROW_W-1:0]   dr_cnt;
    logic [SR_W-1:0]    sr;
    logic [COL_W-1:0]   t;

    logic               rd_acc;
    logic               ref_acc;
    logic               compute;
    logic [SR_W:0]      vec_ext;
    logic [N_PE-1:0]    ivv;

    logic signed [SCORE_W-1:0] cand_score;
    logic [ROW_W-1:0]          cand_row;
    logic [COL_W-1:0]          cand_col;

    // Abort gates every handshake so no beat is consumed on the abort cycle.
    assign rd_acc  = (state == LOAD) && !bus.abort && bus.rd_valid;
    assign ref_acc = (state == STREAM) && !bus.abort && bus.ref_valid;
    assign compute = ref_acc || ((state == DRAIN) && !bus.abort);

    // Wavefront: PE0 is fed by the accepted beat, PE i by PE i-1's history.
    assign vec_ext = {sr, ref_acc};
    assign ivv     = compute ? vec_ext[N_PE-1:0] : '0;

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:   if (bus.start) nxt = CLEAR;
            CLEAR:  nxt = LOAD;
            LOAD:   if (rd_acc && ld_cnt == ROW_W'(N_PE - 1)) nxt = STREAM;
            STREAM: if (ref_acc && bus.ref_last)
                        nxt = (N_PE == 1) ? DONE : DRAIN;
            DRAIN:  if (dr_cnt == ROW_W'(1)) nxt = DONE;
            DONE:   nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (bus.abort && state != IDLE) nxt = IDLE;
    end

    // Strict compare against the running best: lower PE index wins ties
    // within a cycle, earlier cycles win ties across cycles.
    always_comb begin
        cand_score = bus.best_score;
        cand_row   = bus.best_row;
        cand_col   = bus.best_col;
        for (int i = 0; i < N_PE; i++) begin
            if (ivv[i] &&
                $signed(bus.pe_score_in[i*SCORE_W +: SCORE_W]) > cand_score) begin
                cand_score = bus.pe_score_in[i*SCORE_W +: SCORE_W];
                cand_row   = ROW_W'(i);
                cand_col   = t - COL_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            ld_cnt         <= '0;
            dr_cnt         <= '0;
            sr             <= '0;
            t              <= '0;
            bus.best_score <= '0;
            bus.best_row   <= '0;
            bus.best_col   <= '0;
        end else begin
            state <= nxt;
            if (state == CLEAR && !bus.abort) begin
                ld_cnt         <= '0;
                sr             <= '0;
                t              <= '0;
                bus.best_score <= '0;
                bus.best_row   <= '0;
                bus.best_col   <= '0;
            end
            if (rd_acc) ld_cnt <= ld_cnt + 1'b1;
            if (compute) begin
                sr             <= ivv[SR_W-1:0];
                t              <= t + 1'b1;
                bus.best_score <= cand_score;
                bus.best_row   <= cand_row;
                bus.best_col   <= cand_col;
            end
            if (ref_acc && bus.ref_last)
                dr_cnt <= ROW_W'(N_PE - 1);
            else if (state == DRAIN && !bus.abort)
                dr_cnt <= dr_cnt - 1'b1;
        end
    end

    assign bus.rd_ready      = (state == LOAD) && !bus.abort;
    assign bus.ref_ready     = (state == STREAM) && !bus.abort;
    assign bus.clear_en      = (state == CLEAR) && !bus.abort;
    assign bus.read_load_en  = rd_acc ? (N_PE'(1) << ld_cnt) : '0;
    assign bus.read_base_out = rd_acc ? bus.rd_base : 2'b00;
    assign bus.compute_en    = compute;
    assign bus.ref_base_out  = ref_acc ? bus.ref_base : 2'b00;
    assign bus.in_valid_vec  = ivv;
    assign bus.busy          = (state != IDLE) && (state != DONE);
    assign bus.done          = (state == DONE) && !bus.abort;
endmodule

// File: tb/tb_sw_array_ctrl.sv
// Directed bench for sw_array_ctrl with N_PE=4 and a Smith-Waterman
// score model standing in for the PE chain.
module tb_sw_array_ctrl;
    localparam int N  = 4;
    localparam int SW = 8;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sw_array_ctrl_if #(.N_PE(N), .SCORE_W(SW), .COL_W(CW)) bus ();

    sw_array_ctrl #(.N_PE(N), .SCORE_W(SW), .COL_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int nvec = 0;
    int nerr = 0;

    int rdb [4] = '{0, 1, 2, 3};
    int rfb [4];
    int tab [4][8];
    int cur_nref = 4;
    int garb = 100;
    int bt;

    logic [N-1:0] ivq [$];
    logic [N-1:0] lds [4];
    int clr_n, extra_clr, gapbad, dn, busy_at_done;

    // PE model: PE i in compute cycle bt works on column bt-i; cells
    // outside the matrix carry a junk score that must be masked.
    always @(posedge clk or posedge rst) begin
        if (rst) bt <= 0;
        else if (bus.clear_en) bt <= 0;
        else if (bus.compute_en) bt <= bt + 1;
    end

    always_comb begin
        int c;
        bus.pe_score_in = '0;
        for (int i = 0; i < N; i++) begin
            c = bt - i;
            if (c >= 0 && c < cur_nref)
                bus.pe_score_in[i*SW +: SW] = SW'(tab[i][c]);
            else
                bus.pe_score_in[i*SW +: SW] = SW'(garb);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Match +9, mismatch -3, linear gap -4.
    task automatic fill_sw(input int nref);
        int h [5][9];
        int d, u, l, v;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 9; j++) h[i][j] = 0;
        for (int i = 1; i <= N; i++)
            for (int j = 1; j <= nref; j++) begin
                d = h[i-1][j-1] + ((rdb[i-1] == rfb[j-1]) ? 9 : -3);
                u = h[i-1][j] - 4;
                l = h[i][j-1] - 4;
                v = 0;
                if (d > v) v = d;
                if (u > v) v = u;
                if (l > v) v = l;
                h[i][j] = v;
                tab[i-1][j-1] = v;
            end
        cur_nref = nref;
    endtask

    task automatic run_window(input int nref, input int gap_at,
                              input int gaplen, input int hold);
        int k, g, cyc;
        ivq.delete();
        clr_n = 0; extra_clr = 0; gapbad = 0; dn = 0; busy_at_done = 1;
        bus.start = 1'b1;
        tick();
        if (hold == 0) bus.start = 1'b0;
        #3;
        clr_n += int'(bus.clear_en);
        tick();
        for (int b = 0; b < N; b++) begin
            bus.rd_valid = 1'b1;
            bus.rd_base  = 2'(rdb[b]);
            #3;
            lds[b] = bus.read_load_en;
            tick();
        end
        bus.rd_valid = 1'b0;
        k = 0; g = 0; cyc = 0;
        while (k < nref && cyc < 40) begin
            cyc++;
            if (k == gap_at && g < gaplen) begin
                bus.ref_valid = 1'b0;
                g++;
                #3;
                gapbad += int'(bus.compute_en | (|bus.in_valid_vec));
            end else begin
                bus.ref_valid = 1'b1;
                bus.ref_base  = 2'(rfb[k]);
                bus.ref_last  = (k == nref - 1);
                k++;
                #3;
                if (bus.compute_en) ivq.push_back(bus.in_valid_vec);
            end
            extra_clr += int'(bus.clear_en);
            tick();
        end
        bus.ref_valid = 1'b0;
        bus.ref_last  = 1'b0;
        for (int c = 0; c < 20 && dn == 0; c++) begin
            #3;
            if (bus.compute_en) ivq.push_back(bus.in_valid_vec);
            extra_clr += int'(bus.clear_en);
            if (bus.done) begin
                dn = 1;
                busy_at_done = int'(bus.busy);
            end
            tick();
        end
        bus.start = 1'b0;
    endtask

    initial begin
        logic [N-1:0] exp_iv [7];
        logic [N-1:0] exp_iv1 [4];
        int seen_done;
        exp_iv  = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                    4'b1110, 4'b1100, 4'b1000};
        exp_iv1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        bus.start = 0; bus.abort = 0; bus.rd_valid = 0; bus.rd_base = 0;
        bus.ref_valid = 0; bus.ref_base = 0; bus.ref_last = 0;
        rfb = '{0, 1, 2, 3};
        fill_sw(4);

        #12;
        chk("rst_ctrl", {bus.busy, bus.done, bus.rd_ready, bus.ref_ready,
                         bus.clear_en, bus.compute_en}, 0);
        chk("rst_best", {bus.best_score, 6'(bus.best_row), bus.best_col}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Main ACGT vs ACGT window.
        garb = 100;
        run_window(4, -1, 0, 0);
        chk("clear_once", clr_n, 1);
        for (int b = 0; b < N; b++)
            chk($sformatf("load_en%0d", b), lds[b], 32'(1 << b));
        chk("n_compute", ivq.size(), 7);
        for (int i = 0; i < 7 && i < ivq.size(); i++)
            chk($sformatf("ivv%0d", i), ivq[i], exp_iv[i]);
        chk("done", dn, 1);
        chk("busy_at_done", busy_at_done, 0);
        chk("best_score", bus.best_score, 36);
        chk("best_row", bus.best_row, 3);
        chk("best_col", bus.best_col, 3);

        // Same window with a 3-cycle reference gap.
        run_window(4, 2, 3, 0);
        chk("gap_idle", gapbad, 0);
        chk("gap_n_compute", ivq.size(), 7);
        chk("gap_done", dn, 1);
        chk("gap_best", {bus.best_score, 6'(bus.best_row), bus.best_col},
            {8'd36, 6'd3, 16'd3});

        // Ties: PE1/PE2 at 18 in cycle 3, PE3 at 18 in cycle 5.
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 8; j++) tab[i][j] = 0;
        tab[1][2] = 18; tab[2][1] = 18; tab[3][2] = 18;
        cur_nref = 4;
        run_window(4, -1, 0, 0);
        chk("tie_done", dn, 1);
        chk("tie_best", {bus.best_score, 6'(bus.best_row), bus.best_col},
            {8'd18, 6'd1, 16'd2});

        // Non-positive scores everywhere.
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 8; j++) tab[i][j] = ((i + j) % 2) ? -5 : 0;
        garb = -7;
        run_window(4, -1, 0, 0);
        chk("neg_done", dn, 1);
        chk("neg_best", {bus.best_score, 6'(bus.best_row), bus.best_col}, 0);

        // Abort on LOAD beat 2.
        garb = 100;
        fill_sw(4);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        for (int b = 0; b < 2; b++) begin
            bus.rd_valid = 1'b1;
            bus.rd_base  = 2'(rdb[b]);
            tick();
        end
        bus.rd_base = 2'(rdb[2]);
        bus.abort   = 1'b1;
        #3;
        chk("abort_no_load", bus.read_load_en, 0);
        tick();
        bus.abort    = 1'b0;
        bus.rd_valid = 1'b0;
        seen_done = 0;
        #3;
        chk("abort_busy", {bus.busy, bus.rd_ready}, 0);
        for (int c = 0; c < 5; c++) begin
            seen_done += int'(bus.done | bus.busy);
            tick();
        end
        chk("abort_quiet", seen_done, 0);
        run_window(4, -1, 0, 0);
        chk("rerun_done", dn, 1);
        chk("rerun_best", {bus.best_score, 6'(bus.best_row), bus.best_col},
            {8'd36, 6'd3, 16'd3});

        // Reset mid-STREAM.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        for (int b = 0; b < N; b++) begin
            bus.rd_valid = 1'b1;
            bus.rd_base  = 2'(rdb[b]);
            tick();
        end
        bus.rd_valid  = 1'b0;
        bus.ref_valid = 1'b1;
        for (int b = 0; b < 2; b++) begin
            bus.ref_base = 2'(rfb[b]);
            tick();
        end
        chk("pre_rst_best", bus.best_score, 9);
        rst = 1'b1;
        #1;
        chk("mid_rst_ctrl", {bus.busy, bus.done, bus.rd_ready, bus.ref_ready,
                             bus.clear_en, bus.compute_en, bus.in_valid_vec,
                             bus.read_load_en, bus.ref_base_out,
                             bus.read_base_out}, 0);
        chk("mid_rst_best",
            {bus.best_score, 6'(bus.best_row), bus.best_col}, 0);
        bus.ref_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // start held high throughout, ref_last on the first beat.
        rfb = '{0, 0, 0, 0};
        fill_sw(1);
        run_window(1, -1, 0, 1);
        chk("one_clear", clr_n, 1);
        chk("one_no_restart", extra_clr, 0);
        chk("one_n_compute", ivq.size(), 4);
        for (int i = 0; i < 4 && i < ivq.size(); i++)
            chk($sformatf("one_ivv%0d", i), ivq[i], exp_iv1[i]);
        chk("one_done", dn, 1);
        chk("one_best", {bus.best_score, 6'(bus.best_row), bus.best_col},
            {8'd9, 6'd0, 16'd0});

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
